// File: rtl/factor_search_pkg.sv
// Shared types and constants for the sequential factorizer.
// Holds the FSM state encoding, the default factor width and its maximum value.
package factor_pkg;

  localparam int W_DEFAULT = 4;
  localparam int FMAX      = 2**W_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    FIN  = 2'd3
  } fs_state_t;

endpackage

// File: rtl/factor_search_shift_add_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// The go cycle performs the first step, so p is final exactly W cycles after go.
module shift_add_mul
  import factor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p,
  output logic           rdy
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] w_x_ext;

  assign w_x_ext = {{W{1'b0}}, x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (go) begin
      // Load and consume multiplier bit 0 in the same cycle.
      r_acc    <= y[0] ? w_x_ext : '0;
      r_mcand  <= w_x_ext << 1;
      r_mplier <= y >> 1;
      r_cnt    <= CW'(W - 1);
    end else if (r_cnt != '0) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  assign p   = r_acc;
  assign rdy = (r_cnt == '0) && !go;

endmodule

// File: rtl/factor_search.sv
// Sequential factorizer: finds the lexicographically first pair f1 <= f2 with f1*f2 == a.
// Each candidate pair costs W multiply cycles plus one compare cycle.
module factor_search
  import factor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic           nontriv,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [W-1:0]   f1,
  output logic [W-1:0]   f2
);

  localparam int           SW    = $clog2(W + 1);
  localparam logic [W-1:0] LMAX  = {W{1'b1}};
  localparam logic [W-1:0] LO_NT = W'(2);

  fs_state_t      r_state;
  logic [2*W-1:0] r_aq;
  logic [W-1:0]   r_f1;
  logic [W-1:0]   r_f2;
  logic [SW-1:0]  r_step;
  logic           r_busy;
  logic           r_done;
  logic           r_found;
  logic [W-1:0]   r_of1;
  logic [W-1:0]   r_of2;

  logic           w_go;
  logic [2*W-1:0] w_p;
  logic           w_rdy;
  logic           w_eq;
  logic           w_gt;

  assign w_go = (r_state == MUL) && (r_step == '0);
  assign w_eq = (w_p == r_aq);
  assign w_gt = (w_p > r_aq);

  shift_add_mul #(.W(W)) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (w_go),
    .x   (r_f1),
    .y   (r_f2),
    .p   (w_p),
    .rdy (w_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_aq    <= '0;
      r_f1    <= '0;
      r_f2    <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_of1   <= '0;
      r_of2   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_aq    <= a;
            r_f1    <= nontriv ? LO_NT : '0;
            r_f2    <= nontriv ? LO_NT : '0;
            r_found <= 1'b0;
            r_of1   <= '0;
            r_of2   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (r_step == SW'(W - 1)) begin
            r_step  <= '0;
            r_state <= CMP;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        CMP: begin
          if (w_rdy) begin
            if (w_eq) begin
              r_found <= 1'b1;
              r_of1   <= r_f1;
              r_of2   <= r_f2;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else if (w_gt && (r_f2 == r_f1)) begin
              // f1*f1 already exceeds a: every later pair is larger still.
              r_done  <= 1'b1;
              r_state <= FIN;
            end else if (w_gt || (r_f2 == LMAX)) begin
              if (r_f1 == LMAX) begin
                r_done  <= 1'b1;
                r_state <= FIN;
              end else begin
                r_f1    <= r_f1 + 1'b1;
                r_f2    <= r_f1 + 1'b1;
                r_state <= MUL;
              end
            end else begin
              r_f2    <= r_f2 + 1'b1;
              r_state <= MUL;
            end
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign found = r_found;
  assign f1    = r_of1;
  assign f2    = r_of2;

endmodule

// File: tb/tb_factor_search.sv
// Directed bench for factor_search at W=4 with hand-computed pair counts and results.
module tb_factor_search;
  import factor_pkg::FMAX;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic       nontriv;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] f1;
  logic [3:0] f2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  factor_search #(.W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .nontriv (nontriv),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .f1      (f1),
    .f2      (f2)
  );

  // Stimulus helpers: called at posedge+1, return at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] av, input logic nt);
    start   = 1'b1;
    a       = av;
    nontriv = nt;
    step();
    start = 1'b0;
  endtask

  // Edges after the accept edge until done is seen; 1000 means it never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      step();
      cyc++;
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] av, input logic nt);
    logic [8:0] r;
    r = '0;
    for (int i = (nt ? 2 : 0); i <= FMAX; i++)
      for (int j = i; j <= FMAX; j++)
        if (!r[8] && (i * j == int'(av))) r = {1'b1, 4'(i), 4'(j)};
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; nontriv = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done, found, f1, f2} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {busy, done, found, f1, f2});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    int cyc;
    accept(8'h00, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_rise got %b want 1", busy); end
    wait_done(cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL zero_latency got %0d want 5", cyc); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd0, 4'd0}) begin
      errors++; $display("FAIL zero_result got %h want 100", {found, f1, f2});
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_end got busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_composite();
    int cyc;
    accept(8'h8F, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc != 93 * 5) begin errors++; $display("FAIL c143_latency got %0d want %0d", cyc, 93 * 5); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd11, 4'd13}) begin
      errors++; $display("FAIL c143_result got %h want 1bd", {found, f1, f2});
    end
    step();
  endtask

  task automatic test_prime();
    int cyc;
    accept(8'h0D, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc != 50) begin errors++; $display("FAIL prime_nt_latency got %0d want 50", cyc); end
    checks++;
    if ({found, f1, f2} !== 9'd0) begin errors++; $display("FAIL prime_nt_result got %h want 000", {found, f1, f2}); end
    step();
    accept(8'h0D, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != 145) begin errors++; $display("FAIL prime_triv_latency got %0d want 145", cyc); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd1, 4'd13}) begin
      errors++; $display("FAIL prime_triv_result got %h want 11d", {found, f1, f2});
    end
    step();
  endtask

  task automatic test_limits();
    int cyc;
    accept(8'hE1, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != 680) begin errors++; $display("FAIL sq225_latency got %0d want 680", cyc); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd15, 4'd15}) begin
      errors++; $display("FAIL sq225_result got %h want 1ff", {found, f1, f2});
    end
    step();
    accept(8'hFF, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc != 680) begin errors++; $display("FAIL ff_latency got %0d want 680", cyc); end
    checks++;
    if ({found, f1, f2} !== 9'd0) begin errors++; $display("FAIL ff_result got %h want 000", {found, f1, f2}); end
    step();
  endtask

  task automatic test_start_ignored();
    int cyc;
    accept(8'h8F, 1'b1);
    a = 8'h0D; nontriv = 1'b0;
    repeat (20) step();
    start = 1'b1; a = 8'h06;
    step();
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc + 21 != 465) begin errors++; $display("FAIL ignore_latency got %0d want 465", cyc + 21); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd11, 4'd13}) begin
      errors++; $display("FAIL ignore_result got %h want 1bd", {found, f1, f2});
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int dones;
    accept(8'h06, 1'b1);
    wait_done(cyc);
    step();
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd2, 4'd3}) begin
      errors++; $display("FAIL held_result got %h want 123", {found, f1, f2});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({found, f1, f2} !== 9'd0) begin errors++; $display("FAIL async_clear got %h want 000", {found, f1, f2}); end
    step();
    rst = 1'b0;
    accept(8'hE1, 1'b0);
    repeat (30) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mid_abort got busy,done=%b want 00", {busy, done}); end
    step();
    step();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL no_done_after_abort got %0d active cycles want 0", dones); end
    accept(8'h06, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL post_reset_latency got %0d want 10", cyc); end
    checks++;
    if ({found, f1, f2} !== {1'b1, 4'd2, 4'd3}) begin
      errors++; $display("FAIL post_reset_result got %h want 123", {found, f1, f2});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] av;
    logic nt;
    logic [8:0] exp;
    accept(8'h0C, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc != 25 || {found, f1, f2} !== {1'b1, 4'd2, 4'd6}) begin
      errors++; $display("FAIL b2b_first got cyc=%0d res=%h want cyc=25 res=126", cyc, {found, f1, f2});
    end
    step();
    accept(8'h09, 1'b0);
    checks++;
    if ({busy, found, f1, f2} !== {1'b1, 9'd0}) begin
      errors++; $display("FAIL b2b_accept got %h want 200", {busy, found, f1, f2});
    end
    wait_done(cyc);
    checks++;
    if (cyc != 125 || {found, f1, f2} !== {1'b1, 4'd1, 4'd9}) begin
      errors++; $display("FAIL b2b_second got cyc=%0d res=%h want cyc=125 res=119", cyc, {found, f1, f2});
    end
    for (int k = 0; k < 8; k++) begin
      step();
      av  = 8'($urandom_range(0, 255));
      nt  = 1'($urandom_range(0, 1));
      exp = model(av, nt);
      accept(av, nt);
      wait_done(cyc);
      checks++;
      if (cyc >= 1000 || {found, f1, f2} !== exp) begin
        errors++;
        $display("FAIL sweep a=%h nt=%b got cyc=%0d res=%h want res=%h", av, nt, cyc, {found, f1, f2}, exp);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_composite();
    test_prime();
    test_limits();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
